// File: rtl/stop_watch_time_cnt_pkg.sv
// Shared definitions for the stopwatch timekeeping core: FSM states, digit moduli, BCD step.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package stop_watch_time_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam int CS_MOD      = 10;
  localparam int SEC_TEN_MOD = 6;
  localparam int MIN_TEN_MOD = 6;

  // Highest representable time, 59:59.99, as packed BCD digits
  localparam logic [23:0] MAX_COUNT = 24'h595999;

  // Next value of one BCD digit: clear wins, then increment with wrap on carry
  function automatic logic [3:0] bcd_digit_next(input logic [3:0] q,
                                                input logic       inc,
                                                input logic       carry,
                                                input logic       clr);
    logic [3:0] nxt;
    nxt = q;
    if (clr) begin
      nxt = 4'd0;
    end else if (inc) begin
      nxt = carry ? 4'd0 : q + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stop_watch_time_cnt_bcd_digit.sv
// One BCD counter digit of modulus MOD with a combinational carry to the next digit.
// Latency: q updates on the edge after inc/clr; carry is combinational from inc and q.
// Backpressure: none; inc is consumed in the cycle it is asserted.
module stop_watch_bcd_digit
  import stop_watch_time_cnt_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  // Roll over to the next digit when incrementing out of the top value
  assign carry = inc & (q == 4'(MOD - 1));

  // Digit register: clear to zero, otherwise step on inc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 4'd0;
    end else begin
      q <= bcd_digit_next(q, inc, carry, clr);
    end
  end

endmodule

// File: rtl/stop_watch_time_cnt.sv
// Stopwatch core: edge-detects tick/buttons, runs IDLE/RUN/PAUSE/LAP FSM, keeps BCD mm:ss.cc, lap display.
// Latency: input rise sampled at edge N -> event at N+1 -> state, count and outputs at N+2.
// Backpressure: none; every event is a single-cycle pulse consumed when it fires.
module stop_watch_time_cnt
  import stop_watch_time_cnt_pkg::*;
#(
  parameter bit OVF_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pls_100hz,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [23:0] disp_bcd,
  output logic        run_led,
  output logic        lap_led,
  output logic        ovf
);

  logic [1:0]  pls_sr, ss_sr, clr_sr;
  logic        tick, ss_ev, clr_ev;
  state_t      state, state_nxt;
  logic        latch_en, cnt_clr, cnt_req, cnt_en, at_max;
  logic        frozen, frozen_nxt, run_nxt, lap_nxt_led;
  logic [3:0]  q_cs_one, q_cs_ten, q_sec_one, q_sec_ten, q_min_one, q_min_ten;
  logic        c_cs_one, c_cs_ten, c_sec_one, c_sec_ten, c_min_one, c_min_ten;
  logic [5:0]  inc_v, carry_v;
  logic [23:0] live_q, live_nxt, lap_q, lap_nxt;

  // Two-stage input registers and registered rising-edge events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pls_sr <= 2'b00;
      ss_sr  <= 2'b00;
      clr_sr <= 2'b00;
      tick   <= 1'b0;
      ss_ev  <= 1'b0;
      clr_ev <= 1'b0;
    end else begin
      pls_sr <= {pls_sr[0], pls_100hz};
      ss_sr  <= {ss_sr[0], btn_ss};
      clr_sr <= {clr_sr[0], btn_clr};
      tick   <= pls_sr[0] & ~pls_sr[1];
      ss_ev  <= ss_sr[0] & ~ss_sr[1];
      clr_ev <= clr_sr[0] & ~clr_sr[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: start/stop takes priority over clear/lap
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ss_ev) state_nxt = ST_RUN;
      ST_RUN:   if (ss_ev) state_nxt = ST_PAUSE; else if (clr_ev) state_nxt = ST_LAP;
      ST_PAUSE: if (ss_ev) state_nxt = ST_RUN;   else if (clr_ev) state_nxt = ST_IDLE;
      ST_LAP:   if (ss_ev) state_nxt = ST_PAUSE; else if (clr_ev) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath controls and next values of the registered indicators
  always_comb begin
    frozen_nxt  = 1'b0;
    latch_en    = (state == ST_RUN) && (state_nxt == ST_LAP);
    cnt_clr     = (state == ST_PAUSE) && (state_nxt == ST_IDLE);
    cnt_req     = tick && ((state == ST_RUN) || (state == ST_LAP));
    run_nxt     = (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
    lap_nxt_led = (state_nxt == ST_LAP);
    // A pause that follows a lap keeps showing the lap value until PAUSE is left
    case (state)
      ST_RUN:   frozen_nxt = (state_nxt == ST_LAP);
      ST_LAP:   frozen_nxt = (state_nxt != ST_RUN);
      ST_PAUSE: frozen_nxt = (state_nxt == ST_PAUSE) && frozen;
      default:  frozen_nxt = 1'b0;
    endcase
  end

  // In hold mode the count parks at 59:59.99 and ignores ticks until cleared
  assign live_q = {q_min_ten, q_min_one, q_sec_ten, q_sec_one, q_cs_ten, q_cs_one};
  assign at_max = (live_q == MAX_COUNT);
  assign cnt_en = cnt_req & ~(OVF_HOLD & at_max);

  stop_watch_bcd_digit #(.MOD(CS_MOD)) u_cs_one (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_en), .q(q_cs_one), .carry(c_cs_one));
  stop_watch_bcd_digit #(.MOD(CS_MOD)) u_cs_ten (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(c_cs_one), .q(q_cs_ten), .carry(c_cs_ten));
  stop_watch_bcd_digit #(.MOD(CS_MOD)) u_sec_one (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(c_cs_ten), .q(q_sec_one), .carry(c_sec_one));
  stop_watch_bcd_digit #(.MOD(SEC_TEN_MOD)) u_sec_ten (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(c_sec_one), .q(q_sec_ten), .carry(c_sec_ten));
  stop_watch_bcd_digit #(.MOD(CS_MOD)) u_min_one (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(c_sec_ten), .q(q_min_one), .carry(c_min_one));
  stop_watch_bcd_digit #(.MOD(MIN_TEN_MOD)) u_min_ten (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(c_min_one), .q(q_min_ten), .carry(c_min_ten));

  assign inc_v   = {c_min_one, c_sec_ten, c_sec_one, c_cs_ten, c_cs_one, cnt_en};
  assign carry_v = {c_min_ten, c_min_one, c_sec_ten, c_sec_one, c_cs_ten, c_cs_one};

  // Next live count, so the display register changes on the same edge as the digits
  always_comb begin
    live_nxt = '0;
    for (int i = 0; i < 6; i++) begin
      live_nxt[i*4 +: 4] = bcd_digit_next(live_q[i*4 +: 4], inc_v[i], carry_v[i], cnt_clr);
    end
    lap_nxt = latch_en ? live_nxt : lap_q;
  end

  // Lap latch, display source, indicators and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q    <= 24'h000000;
      frozen   <= 1'b0;
      disp_bcd <= 24'h000000;
      run_led  <= 1'b0;
      lap_led  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      lap_q    <= lap_nxt;
      frozen   <= frozen_nxt;
      disp_bcd <= frozen_nxt ? lap_nxt : live_nxt;
      run_led  <= run_nxt;
      lap_led  <= lap_nxt_led;
      if (cnt_clr) begin
        ovf <= 1'b0;
      end else if (cnt_req && at_max) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stop_watch_time_cnt.sv
// Directed bench for the stopwatch core: wrap and hold variants driven in lockstep.
// Latency: outputs sampled on falling edges, several cycles after each stimulus.
// Backpressure: none.
module tb_stop_watch_time_cnt;

  logic        clk;
  logic        rst;
  logic        pls_100hz;
  logic        btn_ss;
  logic        btn_clr;
  logic [23:0] disp0, disp1;
  logic        run0, run1, lap0, lap1, ovf0, ovf1;
  logic [23:0] pv;
  int          n_cmp;
  int          n_fail;

  stop_watch_time_cnt #(.OVF_HOLD(1'b0)) dut (
    .clk(clk), .rst(rst), .pls_100hz(pls_100hz), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .disp_bcd(disp0), .run_led(run0), .lap_led(lap0), .ovf(ovf0));

  stop_watch_time_cnt #(.OVF_HOLD(1'b1)) dut_h (
    .clk(clk), .rst(rst), .pls_100hz(pls_100hz), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .disp_bcd(disp1), .run_led(run1), .lap_led(lap1), .ovf(ovf1));

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pls_100hz = 1'b1;
      @(negedge clk) pls_100hz = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic c);
    @(negedge clk);
    btn_ss  = s;
    btn_clr = c;
    repeat (2) @(negedge clk);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Tick and start/stop rising in the same cycle
  task automatic tick_with_ss();
    @(negedge clk);
    pls_100hz = 1'b1;
    btn_ss    = 1'b1;
    @(negedge clk) pls_100hz = 1'b0;
    @(negedge clk) btn_ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Load the live count of both instances while they sit in PAUSE
  task automatic preload(input logic [23:0] v);
    pv = v;
    force dut.u_cs_one.q    = pv[3:0];
    force dut.u_cs_ten.q    = pv[7:4];
    force dut.u_sec_one.q   = pv[11:8];
    force dut.u_sec_ten.q   = pv[15:12];
    force dut.u_min_one.q   = pv[19:16];
    force dut.u_min_ten.q   = pv[23:20];
    force dut_h.u_cs_one.q  = pv[3:0];
    force dut_h.u_cs_ten.q  = pv[7:4];
    force dut_h.u_sec_one.q = pv[11:8];
    force dut_h.u_sec_ten.q = pv[15:12];
    force dut_h.u_min_one.q = pv[19:16];
    force dut_h.u_min_ten.q = pv[23:20];
    repeat (2) @(negedge clk);
    release dut.u_cs_one.q;
    release dut.u_cs_ten.q;
    release dut.u_sec_one.q;
    release dut.u_sec_ten.q;
    release dut.u_min_one.q;
    release dut.u_min_ten.q;
    release dut_h.u_cs_one.q;
    release dut_h.u_cs_ten.q;
    release dut_h.u_sec_one.q;
    release dut_h.u_sec_ten.q;
    release dut_h.u_min_one.q;
    release dut_h.u_min_ten.q;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    pv = 24'h0;
    rst = 1'b0;
    pls_100hz = 1'b0;
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_disp", disp0, 24'h000000);
    chk1("reset_run_led", run0, 1'b0);
    chk1("reset_lap_led", lap0, 1'b0);
    chk1("reset_ovf", ovf0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Start and count
    press(1'b1, 1'b0);
    chk1("start_run_led", run0, 1'b1);
    ticks(123);
    chk("count_123", disp0, 24'h000123);
    chk1("count_run_led", run0, 1'b1);
    chk1("count_ovf", ovf0, 1'b0);

    // Pause at 00:01.50, ticks ignored, then clear
    ticks(27);
    press(1'b1, 1'b0);
    chk1("pause_run_led", run0, 1'b0);
    ticks(50);
    chk("pause_hold", disp0, 24'h000150);
    press(1'b0, 1'b1);
    chk("clear_disp", disp0, 24'h000000);
    chk1("clear_ovf", ovf0, 1'b0);
    chk1("clear_run_led", run0, 1'b0);
    press(1'b0, 1'b1);
    chk("idle_clr_disp", disp0, 24'h000000);
    chk1("idle_clr_run_led", run0, 1'b0);

    // Lap freeze and release
    press(1'b1, 1'b0);
    ticks(500);
    chk("run_500", disp0, 24'h000500);
    press(1'b0, 1'b1);
    chk1("lap_led_on", lap0, 1'b1);
    chk1("lap_run_led", run0, 1'b1);
    ticks(300);
    chk("lap_frozen", disp0, 24'h000500);
    press(1'b0, 1'b1);
    chk("lap_release", disp0, 24'h000800);
    chk1("lap_led_off", lap0, 1'b0);

    // Lap then pause keeps the frozen value; resume shows live
    press(1'b0, 1'b1);
    ticks(100);
    press(1'b1, 1'b0);
    chk("lap_pause_frozen", disp0, 24'h000800);
    chk1("lap_pause_run_led", run0, 1'b0);
    press(1'b1, 1'b0);
    chk("pause_resume_live", disp0, 24'h000900);

    // Both buttons together in RUN: stop wins, no lap
    press(1'b1, 1'b1);
    chk1("simul_run_led", run0, 1'b0);
    chk1("simul_lap_led", lap0, 1'b0);
    chk("simul_disp", disp0, 24'h000900);
    press(1'b1, 1'b0);

    // Tick coincident with stop is counted, with start is not
    tick_with_ss();
    chk("tick_on_stop", disp0, 24'h000901);
    chk1("tick_on_stop_run_led", run0, 1'b0);
    press(1'b0, 1'b1);
    tick_with_ss();
    chk("tick_on_start", disp0, 24'h000000);
    chk1("tick_on_start_run_led", run0, 1'b1);

    // Seconds to minutes cascade
    ticks(5999);
    chk("cascade_005999", disp0, 24'h005999);
    ticks(1);
    chk("cascade_010000", disp0, 24'h010000);

    // Minute-ones to minute-tens cascade
    press(1'b1, 1'b0);
    preload(24'h095999);
    press(1'b1, 1'b0);
    chk("preload_095999", disp0, 24'h095999);
    ticks(1);
    chk("cascade_100000", disp0, 24'h100000);
    chk("cascade_100000_h", disp1, 24'h100000);

    // Top of range: wrap vs hold
    press(1'b1, 1'b0);
    preload(24'h595999);
    press(1'b1, 1'b0);
    chk("preload_595999", disp0, 24'h595999);
    chk("preload_595999_h", disp1, 24'h595999);
    chk1("pre_ovf", ovf0, 1'b0);
    ticks(1);
    chk("wrap_disp", disp0, 24'h000000);
    chk1("wrap_ovf", ovf0, 1'b1);
    chk("hold_disp", disp1, 24'h595999);
    chk1("hold_ovf", ovf1, 1'b1);
    ticks(5);
    chk("wrap_after5", disp0, 24'h000005);
    chk1("wrap_ovf_sticky", ovf0, 1'b1);
    chk("hold_after5", disp1, 24'h595999);

    // Clear releases both overflow flags
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("wrap_clear_disp", disp0, 24'h000000);
    chk1("wrap_clear_ovf", ovf0, 1'b0);
    chk("hold_clear_disp", disp1, 24'h000000);
    chk1("hold_clear_ovf", ovf1, 1'b0);

    // Asynchronous reset in the middle of a run
    press(1'b1, 1'b0);
    ticks(10);
    chk("prereset_disp", disp0, 24'h000010);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_disp", disp0, 24'h000000);
    chk1("areset_run_led", run0, 1'b0);
    chk1("areset_lap_led", lap0, 1'b0);
    chk1("areset_ovf", ovf0, 1'b0);
    chk("areset_disp_h", disp1, 24'h000000);
    chk1("areset_run_led_h", run1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
